// File: rtl/slot_allocator_pkg.sv
// Shared types for the slot allocator: default slot count and the slot index type.
package slot_allocator_pkg;

    localparam int NUM_SLOTS_DEFAULT = 8;

    typedef logic [$clog2(NUM_SLOTS_DEFAULT)-1:0] slot_idx_t;

endpackage

// File: rtl/slot_allocator_free_slot_encoder.sv
// Combinational lowest-index-zero finder over the busy bitmap.
module free_slot_encoder
    import slot_allocator_pkg::*;
#(
    parameter int NUM_SLOTS      = NUM_SLOTS_DEFAULT,
    parameter int SLOT_IDX_WIDTH = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0]      bitmap,
    output logic [SLOT_IDX_WIDTH-1:0] idx,
    output logic                      found
);

    // Scan from the top down so the last hit written is the lowest free index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!bitmap[i]) begin
                idx   = SLOT_IDX_WIDTH'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slot_allocator.sv
// Slot allocator: grants the lowest free slot one cycle after a request,
// tracks busy slots in a bitmap, and supports single-slot free and flush.
module slot_allocator
    import slot_allocator_pkg::*;
#(
    parameter int NUM_SLOTS      = NUM_SLOTS_DEFAULT,
    parameter int SLOT_IDX_WIDTH = $clog2(NUM_SLOTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alloc_req,
    output logic                      alloc_grant,
    output logic [SLOT_IDX_WIDTH-1:0] alloc_slot,
    output logic                      alloc_fail,
    input  logic                      free_en,
    input  logic [SLOT_IDX_WIDTH-1:0] free_slot,
    input  logic                      flush,
    output logic [SLOT_IDX_WIDTH:0]   busy_count,
    output logic                      full,
    output logic                      empty,
    output logic                      free_error
);

    localparam logic [NUM_SLOTS-1:0]    ONE_HOT0  = NUM_SLOTS'(1);
    localparam logic [SLOT_IDX_WIDTH:0] COUNT_MAX = (SLOT_IDX_WIDTH+1)'(NUM_SLOTS);

    logic [NUM_SLOTS-1:0]      busy_map;
    logic [SLOT_IDX_WIDTH-1:0] sel_idx;
    logic                      sel_found;
    logic                      grant_now;
    logic                      free_valid;
    logic                      free_bad;
    logic [NUM_SLOTS-1:0]      set_mask;
    logic [NUM_SLOTS-1:0]      clr_mask;

    free_slot_encoder #(
        .NUM_SLOTS      (NUM_SLOTS),
        .SLOT_IDX_WIDTH (SLOT_IDX_WIDTH)
    ) u_encoder (
        .bitmap (busy_map),
        .idx    (sel_idx),
        .found  (sel_found)
    );

    // Selection uses the pre-free bitmap, so a slot freed this cycle is never
    // granted in the same cycle; the set and clear masks are therefore disjoint.
    always_comb begin
        grant_now  = alloc_req && sel_found;
        free_valid = free_en && busy_map[free_slot];
        free_bad   = free_en && !busy_map[free_slot];
        set_mask   = grant_now  ? (ONE_HOT0 << sel_idx)   : '0;
        clr_mask   = free_valid ? (ONE_HOT0 << free_slot) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_map    <= '0;
            busy_count  <= '0;
            alloc_grant <= 1'b0;
            alloc_slot  <= '0;
            alloc_fail  <= 1'b0;
            free_error  <= 1'b0;
        end else if (flush) begin
            busy_map    <= '0;
            busy_count  <= '0;
            alloc_grant <= 1'b0;
            alloc_fail  <= 1'b0;
        end else begin
            busy_map    <= (busy_map | set_mask) & ~clr_mask;
            busy_count  <= busy_count + (SLOT_IDX_WIDTH+1)'(grant_now)
                                      - (SLOT_IDX_WIDTH+1)'(free_valid);
            alloc_grant <= grant_now;
            alloc_fail  <= alloc_req && !sel_found;
            if (grant_now)
                alloc_slot <= sel_idx;
            if (free_bad)
                free_error <= 1'b1;
        end
    end

    assign full  = (busy_count == COUNT_MAX);
    assign empty = (busy_count == '0);

endmodule

// File: doc/slot_allocator.md
SLOT_ALLOCATOR -- requirements
Module: slot_allocator

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8: number of allocatable slots, power of two, 2..64.
REQ-002 SHALL have parameter SLOT_IDX_WIDTH, default $clog2(NUM_SLOTS): slot index width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: port clk (input, 1, clock) and port reset (input, 1, asynchronous active-low reset).
REQ-004 SHALL have port alloc_req, input, 1: request one free slot this cycle.
REQ-005 SHALL have port alloc_grant, output, 1: registered; slot granted for the previous cycle's request.
REQ-006 SHALL have port alloc_slot, output, SLOT_IDX_WIDTH: registered index of the granted slot; valid only with alloc_grant.
REQ-007 SHALL have port alloc_fail, output, 1: registered; the previous cycle's request was refused because no slot was free.
REQ-008 SHALL have port free_en, input, 1: release one slot this cycle.
REQ-009 SHALL have port free_slot, input, SLOT_IDX_WIDTH: index of the slot being released.
REQ-010 SHALL have port flush, input, 1: release all slots.
REQ-011 SHALL have port busy_count, output, SLOT_IDX_WIDTH+1: number of busy slots.
REQ-012 SHALL have ports full and empty, both output, 1: busy_count==NUM_SLOTS and busy_count==0 respectively.
REQ-013 SHALL have port free_error, output, 1: sticky; set when a slot that is not busy is freed.

Function
REQ-014 SHALL hold a NUM_SLOTS-bit busy bitmap and a busy_count register; busy_count SHALL always equal the popcount of the bitmap.
REQ-015 On alloc_req with at least one free slot, SHALL select the lowest-index zero bit of the current bitmap, set it, and assert alloc_grant with alloc_slot equal to that index on the next cycle (1-cycle latency).
REQ-016 On alloc_req with the bitmap full, SHALL assert alloc_fail, with alloc_grant low, on the next cycle; the bitmap SHALL be unchanged.
REQ-017 alloc_grant and alloc_fail SHALL each be high for exactly one cycle per request and SHALL never be high together; with no request, both SHALL be 0 on the next cycle.
REQ-018 On free_en for a busy slot, SHALL clear its bit on the next edge.
REQ-019 On free_en for a free slot, SHALL leave the bitmap unchanged and set free_error; free_error clears only on reset.
REQ-020 Simultaneous alloc_req and free_en SHALL both take effect in the same cycle; selection SHALL use the pre-free bitmap, so the slot being freed is not granted that cycle; busy_count SHALL be net unchanged.
REQ-021 alloc_req while full, with a simultaneous free_en, SHALL produce alloc_fail; the free still takes effect.
REQ-022 flush SHALL clear the bitmap and busy_count on the next edge and SHALL override alloc_req and free_en that cycle: no grant, no fail, no free_error update.
REQ-023 Multiple consecutive-cycle requests SHALL be served back to back at one grant per cycle, each seeing the bitmap updated by the previous grant.
REQ-024 free_slot values of NUM_SLOTS or more SHALL NOT occur while NUM_SLOTS is a power of two, since every index is then in range.

Reset
REQ-025 Assertion of reset (low) SHALL immediately clear the bitmap, busy_count, alloc_grant, alloc_fail and free_error, with empty=1 and full=0, regardless of any in-flight request.
REQ-026 A request presented in the cycle reset deasserts SHALL be served normally, with a grant one cycle later.

Structure
REQ-027 The lowest-free-index selection SHALL be a separate combinational sub-module, free_slot_encoder: a bitmap input, and an index output plus a found flag.
REQ-028 The slot index typedef (slot_idx_t) and NUM_SLOTS default SHALL reside in the shared core package; everything else is local.
REQ-029 All state SHALL be in a single always_ff with asynchronous active-low reset; there are no other clocks.

Verification
REQ-030 Reset, then alloc_req high for 8 cycles -> grants with slots 0,1,...,7 on cycles 1..8; full=1, busy_count=8.
REQ-031 Full, alloc_req -> alloc_fail=1 next cycle, alloc_grant=0, busy_count stays 8.
REQ-032 Slots 0-7 busy, free_en slot 3 plus alloc_req the same cycle -> alloc_fail (pre-free full); next alloc_req -> alloc_slot=3.
REQ-033 Slots 0-2 busy, free_en slot 5 -> free_error=1 sticky, busy_count stays 3; next alloc_req -> slot 3.
REQ-034 Slots 0-4 busy, flush plus alloc_req plus free_en slot 1 -> no grant, no fail, busy_count=0, empty=1; next alloc_req -> slot 0.
REQ-035 Reset asserted mid-request-burst -> outputs cleared immediately; after release, the first request grants slot 0.
